// File: rtl/xr_host_port.sv
// rtl/xr_host_port.sv - host-side XR access sequencer (optional increment register: XR_PORT_INCR_EN)
module xr_host_port #(
  parameter logic [15:0] DEFAULT_INCR = 16'h0001
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        rd_addr_wr_i,
  input  logic        wr_addr_wr_i,
  input  logic        incr_wr_i,
  input  logic        data_wr_i,
  input  logic        data_rd_i,
  input  logic [15:0] reg_data_i,
  output logic [15:0] rd_data_o,
  output logic        busy_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic        xr_sel_o,
  output logic        xr_wr_o,
  output logic [15:0] xr_addr_o,
  output logic [15:0] xr_data_o,
  input  logic        xr_ack_i,
  input  logic [15:0] xr_data_i
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t      state;
  logic [15:0] rd_addr;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic [15:0] incr;
  logic        wr_pend;
  logic        rd_pend;
  logic        rd_stale;

`ifdef XR_PORT_INCR_EN
  logic [15:0] incr_q;

  // Host-programmable auto-increment step
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      incr_q <= DEFAULT_INCR;
    end else if (incr_wr_i) begin
      incr_q <= reg_data_i;
    end
  end

  assign incr = incr_q;
`else
  logic unused_incr_wr;
  assign unused_incr_wr = incr_wr_i;
  assign incr = DEFAULT_INCR;
`endif

  // Decoded events for this cycle; writes always win arbitration out of IDLE
  logic wr_ack;
  logic rd_ack;
  logic start_rd;
  logic wr_accept;
  logic wr_drop;

  assign wr_ack    = (state == WRITE) && xr_ack_i;
  assign rd_ack    = (state == READ) && xr_ack_i;
  assign start_rd  = (state == IDLE) && !wr_pend && rd_pend;
  // An ack in the same cycle frees the slot, so the new write is taken cleanly
  assign wr_accept = data_wr_i && (!wr_pend || wr_ack);
  assign wr_drop   = data_wr_i && wr_pend && !wr_ack;

  assign busy_o = wr_pend | rd_pend | (state == READ);

  // Host strobe bookkeeping, sequencing FSM and registered XR bus outputs
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state     <= IDLE;
      rd_addr   <= 16'h0000;
      wr_addr   <= 16'h0000;
      wr_data   <= 16'h0000;
      wr_pend   <= 1'b0;
      rd_pend   <= 1'b0;
      rd_stale  <= 1'b0;
      err_o     <= 1'b0;
      rd_data_o <= 16'h0000;
      xr_sel_o  <= 1'b0;
      xr_wr_o   <= 1'b0;
      xr_addr_o <= 16'h0000;
      xr_data_o <= 16'h0000;
    end else begin
      // A host load of an address overrides the post-access increment
      if (wr_addr_wr_i) begin
        wr_addr <= reg_data_i;
      end else if (wr_ack) begin
        wr_addr <= wr_addr + incr;
      end

      if (rd_addr_wr_i) begin
        rd_addr <= reg_data_i;
      end else if (rd_ack && !rd_stale) begin
        rd_addr <= rd_addr + incr;
      end

      if (wr_accept) begin
        wr_data <= reg_data_i;
        wr_pend <= 1'b1;
      end else if (wr_ack) begin
        wr_pend <= 1'b0;
      end

      // New prefetch requests survive the clear taken on read launch
      if (rd_addr_wr_i || data_rd_i) begin
        rd_pend <= 1'b1;
      end else if (start_rd) begin
        rd_pend <= 1'b0;
      end

      // A read launched or in flight against the old address must be discarded
      if (rd_addr_wr_i && ((state == READ) || start_rd)) begin
        rd_stale <= 1'b1;
      end else if (start_rd) begin
        rd_stale <= 1'b0;
      end

      if (wr_drop) begin
        err_o <= 1'b1;
      end else if (err_clr_i) begin
        err_o <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (wr_pend) begin
            state     <= WRITE;
            xr_sel_o  <= 1'b1;
            xr_wr_o   <= 1'b1;
            xr_addr_o <= wr_addr;
            xr_data_o <= wr_data;
          end else if (rd_pend) begin
            state     <= READ;
            xr_sel_o  <= 1'b1;
            xr_wr_o   <= 1'b0;
            xr_addr_o <= rd_addr;
          end
        end
        WRITE: begin
          if (xr_ack_i) begin
            state    <= IDLE;
            xr_sel_o <= 1'b0;
          end
        end
        READ: begin
          if (xr_ack_i) begin
            state    <= IDLE;
            xr_sel_o <= 1'b0;
            if (!rd_stale) begin
              rd_data_o <= xr_data_i;
            end
          end
        end
        default: begin
          state    <= IDLE;
          xr_sel_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/xr_host_port.md
Name: xr_host_port

Overview:
Host-side XR access sequencer that sits directly upstream of the XR memory arbiter's host (non-copper) XR port.
- Converts host register strobes (XR read address, XR write address, increment, XR data read/write) into single-outstanding XR bus transactions.
- Provides read prefetch and post-access address auto-increment.
- Holds each request on the XR bus until the arbiter acknowledges it; the arbiter may delay acknowledgement while it services copper priority writes.

Parameters:
DEFAULT_INCR, 16'h0001, address increment applied after each XR data access (the fixed increment when XR_PORT_INCR_EN is undefined; the reset value of the increment register when defined)

Ports:
clk  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
rd_addr_wr_i  in  1  strobe: load read address from reg_data_i, start prefetch
wr_addr_wr_i  in  1  strobe: load write address from reg_data_i
incr_wr_i  in  1  strobe: load increment from reg_data_i (ignored if XR_PORT_INCR_EN undefined)
data_wr_i  in  1  strobe: host writes XR data (reg_data_i)
data_rd_i  in  1  strobe: host consumed rd_data_o
reg_data_i  in  16  host write data
rd_data_o  out  16  prefetched XR read data
busy_o  out  1  write pending/in flight or prefetch not yet valid
err_o  out  1  sticky: data write dropped while a write was pending
err_clr_i  in  1  clears err_o
xr_sel_o  out  1  XR request to arbiter
xr_wr_o  out  1  request is write
xr_addr_o  out  16  XR address
xr_data_o  out  16  XR write data
xr_ack_i  in  1  arbiter acknowledge (registered in arbiter)
xr_data_i  in  16  XR read data, valid in the cycle xr_ack_i=1

Behaviour:
- Reset: all outputs 0.
  - rd_addr, wr_addr, wr_data = 0; incr = DEFAULT_INCR.
  - Flags wr_pend, rd_pend, rd_stale, err = 0; state IDLE.
- All xr_* outputs are registered.
- wr_addr_wr_i: wr_addr <= reg_data_i.
- rd_addr_wr_i: rd_addr <= reg_data_i; rd_pend <= 1.
  - If a read is in flight, set rd_stale.
- data_wr_i:
  - If wr_pend=0: wr_data <= reg_data_i, wr_pend <= 1.
  - Otherwise the write is dropped and err <= 1.
- data_rd_i: rd_pend <= 1 (prefetch next).
- Simultaneous strobes apply independently. err_clr_i and a same-cycle error set: the set wins.
- FSM states:
  - IDLE: if wr_pend, go to WRITE (write has priority); else if rd_pend, go to READ.
    - On entry to WRITE: xr_sel_o=1, xr_wr_o=1, xr_addr_o=wr_addr, xr_data_o=wr_data.
    - On entry to READ: xr_sel_o=1, xr_wr_o=0, xr_addr_o=rd_addr; clear rd_pend and rd_stale.
  - WRITE: hold all xr_* stable until xr_ack_i=1. At that edge: xr_sel_o <= 0, wr_pend <= 0, wr_addr <= wr_addr + incr, go to IDLE.
  - READ: hold until xr_ack_i=1. At that edge: xr_sel_o <= 0, go to IDLE.
    - If rd_stale=0: rd_data_o <= xr_data_i and rd_addr <= rd_addr + incr.
    - If rd_stale=1 (address reloaded mid-flight): discard the data; rd_pend is already 1, so a new prefetch follows.
- xr_sel_o is low for at least one cycle after every ack, which the arbiter requires so it does not double-acknowledge.
  - Minimum request latency: 1 cycle from sel to ack.
  - Back-to-back transactions: 3 cycles each.
- Address arithmetic: 16-bit, wraps mod 2^16 (FFFF + 1 = 0000). incr is treated as unsigned/two's complement, so increment 16'hFFFF decrements.
- busy_o = wr_pend | rd_pend | (state==READ). Combinational from registers, glitch-free at the clock edge.
- data_wr_i in the same cycle as the write ack: the ack clears the old pending write, the new one is accepted, and there is no error.
- Reset asserted mid-transaction: immediate return to reset values; xr_sel_o drops asynchronously.

Optional Feature:
XR_PORT_INCR_EN:
- Defined: 16-bit increment register, written by incr_wr_i, reset to DEFAULT_INCR.
- Undefined: no register; incr is the constant DEFAULT_INCR and incr_wr_i is ignored.

Test Plan:
- Reset, then rd_addr_wr_i with 16'h8000, ack after 1 cycle, xr_data_i=16'h0ABC -> xr_addr_o=8000, rd_data_o=0ABC, rd_addr=8001, busy_o falls to 0; data_rd_i then issues a read at 8001.
- wr_addr_wr_i 16'hA000, then three data_wr_i (1111, 2222, 3333), each issued after busy_o drops -> writes at A000/A001/A002 with matching data; xr_sel_o low ≥1 cycle between them.
- Arbiter holds xr_ack_i low for 5 cycles (copper busy) during a write -> xr_sel_o, xr_wr_o, xr_addr_o, xr_data_o stable for all 5 cycles; a second data_wr_i in that window -> err_o=1 and the second write never appears; err_clr_i -> err_o=0.
- Read in flight at 0x0010, rd_addr_wr_i 0x0200 before ack -> the ack data is discarded, a new read at 0x0200 follows, and rd_data_o reflects the 0x0200 data only.
- Write and prefetch pending together -> write issued first, then read; wr_addr 16'hFFFF with increment 1 wraps to 16'h0000.
- With XR_PORT_INCR_EN defined, incr_wr_i 16'h0004 and rd_addr 0x0100 -> successive reads at 0100, 0104, 0108; with it undefined, same stimulus -> 0100, 0101, 0102.
